// File: rtl/sirv_queue_p.sv
// Circular-buffer FIFO with occupancy, almost-full/empty flags and a high-water mark.
// Define SIRV_QUEUE_P_FLOW_EN for zero-latency flow-through when the queue is empty.
module sirv_queue_p #(
    parameter int DW     = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_enq_valid,
    output logic                     io_enq_ready,
    input  logic [DW-1:0]            io_enq_bits,
    input  logic                     io_deq_ready,
    output logic                     io_deq_valid,
    output logic [DW-1:0]            io_deq_bits,
    input  logic                     io_flush,
    input  logic                     io_hwm_clr,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_almost_full,
    output logic                     io_almost_empty,
    output logic [$clog2(DEPTH):0]   io_hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AfThr = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AeThr = (AW+1)'(AE_LVL);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic          maybeFull_q, maybeFull_d;
    logic [AW:0]   hwm_q, hwm_d;

    logic          ptrMatch;
    logic          empty;
    logic          full;
    logic          enqReady;
    logic          deqValid;
    logic [DW-1:0] deqBits;
    logic          doEnq;
    logic          doDeq;
    logic [AW:0]   count;
    logic [AW:0]   nextCount;

    assign ptrMatch = (wrPtr_q == rdPtr_q);
    assign empty    = ptrMatch & ~maybeFull_q;
    assign full     = ptrMatch & maybeFull_q;
    assign enqReady = ~full & ~io_flush;
    assign count    = {full, wrPtr_q - rdPtr_q};

    // Handshake decode; flow-through bypasses storage entirely when empty.
    always_comb begin
        deqValid = ~empty & ~io_flush;
        deqBits  = mem_q[rdPtr_q];
        doEnq    = io_enq_valid & enqReady;
        doDeq    = deqValid & io_deq_ready;
`ifdef SIRV_QUEUE_P_FLOW_EN
        if (empty && !io_flush) begin
            deqValid = io_enq_valid;
            deqBits  = io_enq_bits;
            doEnq    = io_enq_valid & enqReady & ~io_deq_ready;
            doDeq    = 1'b0;
        end
`endif
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        maybeFull_d = maybeFull_q;
        nextCount   = count + {{AW{1'b0}}, doEnq} - {{AW{1'b0}}, doDeq};
        if (io_flush) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            maybeFull_d = 1'b0;
            nextCount   = '0;
        end else begin
            if (doEnq) wrPtr_d = wrPtr_q + AW'(1);
            if (doDeq) rdPtr_d = rdPtr_q + AW'(1);
            if (doEnq != doDeq) maybeFull_d = doEnq;
        end
    end

    // Clear takes priority so the mark restarts from the occupancy about to be reached.
    always_comb begin
        hwm_d = hwm_q;
        if (io_hwm_clr) begin
            hwm_d = nextCount;
        end else if (nextCount > hwm_q) begin
            hwm_d = nextCount;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            maybeFull_q <= 1'b0;
            hwm_q       <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            maybeFull_q <= maybeFull_d;
            hwm_q       <= hwm_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doEnq) begin
            mem_q[wrPtr_q] <= io_enq_bits;
        end
    end

    assign io_enq_ready    = enqReady;
    assign io_deq_valid    = deqValid;
    assign io_deq_bits     = deqBits;
    assign io_count        = count;
    assign io_almost_full  = (count >= AfThr);
    assign io_almost_empty = (count <= AeThr);
    assign io_hwm          = hwm_q;

endmodule

// File: doc/sirv_queue_p.md
SIRV_QUEUE_P -- requirements
Module: sirv_queue_p

Interface
REQ-001 Parameter DW, 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, 8, entry count (power of two, >=2); AW = log2(DEPTH).
REQ-003 Parameter AF_LVL, DEPTH-2, almost-full threshold (1..DEPTH).
REQ-004 Parameter AE_LVL, 1, almost-empty threshold (0..DEPTH-1).
REQ-005 clock  input  1  clock, all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 io_enq_valid  input  1  producer offers io_enq_bits.
REQ-008 io_enq_ready  output  1  queue accepts an entry this cycle.
REQ-009 io_enq_bits  input  DW  write data.
REQ-010 io_deq_ready  input  1  consumer accepts io_deq_bits.
REQ-011 io_deq_valid  output  1  head entry available.
REQ-012 io_deq_bits  output  DW  head entry data.
REQ-013 io_flush  input  1  discard all entries.
REQ-014 io_hwm_clr  input  1  clear high-water mark.
REQ-015 io_count  output  AW+1  occupancy, 0..DEPTH.
REQ-016 io_almost_full  output  1  io_count >= AF_LVL.
REQ-017 io_almost_empty  output  1  io_count <= AE_LVL.
REQ-018 io_hwm  output  AW+1  max io_count since reset/clear.

Function
REQ-019 Storage SHALL be a DEPTH x DW array with AW-bit write pointer, AW-bit read pointer and a maybe_full bit.
REQ-020 ptr_match = (wptr == rptr); empty = ptr_match & !maybe_full; full = ptr_match & maybe_full.
REQ-021 io_enq_ready = !full & !io_flush; io_deq_valid = !empty & !io_flush; io_deq_bits = array[rptr] (combinational read).
REQ-022 do_enq = io_enq_valid & io_enq_ready writes array[wptr] and increments wptr modulo DEPTH (natural AW-bit wrap).
REQ-023 do_deq = io_deq_valid & io_deq_ready increments rptr modulo DEPTH.
REQ-024 maybe_full <= do_enq when do_enq != do_deq; otherwise unchanged.
REQ-025 Simultaneous do_enq and do_deq: both pointers advance, occupancy unchanged.
REQ-026 Full: no enqueue (io_enq_ready=0), even if io_deq_ready=1 in the same cycle.
REQ-027 io_count = {full, wptr - rptr} (low AW bits of the difference).
REQ-028 io_flush: wptr, rptr, maybe_full <= 0 next edge; enq/deq blocked in the flush cycle; array contents unchanged; io_hwm unaffected.
REQ-029 io_hwm <= next occupancy when next occupancy > io_hwm; io_hwm_clr loads the next occupancy instead (clear priority).
REQ-030 Enq/deq latency: data enqueued at edge N is visible on io_deq_bits with io_deq_valid=1 in cycle N+1 (macro off).

Reset
REQ-031 Reset SHALL clear wptr, rptr, maybe_full and io_hwm; array not reset.
REQ-032 During/after reset: io_enq_ready=1, io_deq_valid=0, io_count=0, io_almost_empty=1, io_almost_full=(AF_LVL==0)=0, io_hwm=0.
REQ-033 Reset mid-operation SHALL discard all entries immediately (asynchronous).

Configuration
REQ-034 Macro SIRV_QUEUE_P_FLOW_EN defined: when empty and not flushing, io_deq_valid = io_enq_valid and io_deq_bits = io_enq_bits (zero-latency flow-through); if io_deq_ready=1 the entry is consumed without write or pointer change; otherwise it is stored normally.
REQ-035 Macro undefined: no flow-through; REQ-021/REQ-030 apply unchanged.

Verification
REQ-036 DW=8, DEPTH=8: enqueue 0x01..0x08 with deq_ready=0 -> io_count=8, enq_ready=0, almost_full=1; drain -> 0x01..0x08 in order, count 0.
REQ-037 Fill 5, then 20 cycles enq_valid=deq_ready=1 -> count stays 5, pointers wrap past 7->0, data order preserved.
REQ-038 Full queue, enq_valid=1, deq_ready=1 -> one dequeue, no enqueue, count 8->7.
REQ-039 Count 6, assert io_flush one cycle -> count 0, deq_valid 0, hwm stays 6; hwm_clr -> hwm 0.
REQ-040 Assert reset with count 3 mid-stream -> outputs per REQ-032 within same cycle.
REQ-041 SIRV_QUEUE_P_FLOW_EN defined, empty, enq_valid=1 bits=0xA5, deq_ready=1 -> deq_valid=1, deq_bits=0xA5 same cycle, count stays 0.
